// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants and requester identifiers for the register-file
// writeback scheduler.
package regfile_wb_sched_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 32;
  localparam int ADDR_W     = 5;

  localparam logic [ADDR_W-1:0] ADDR_X0 = 5'd0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_t;
endpackage

// File: rtl/regfile_wb_sched_if.sv
// Issue and writeback handshake bundle; master drives requests,
// slave (the scheduler) returns stall and grants.
interface regfile_wb_sched_if #(parameter int DATA_W = regfile_wb_sched_pkg::DATA_W_DEF);
  import regfile_wb_sched_pkg::*;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_stall;

  logic              alu_wb_valid;
  logic [ADDR_W-1:0] alu_wb_rd;
  logic [DATA_W-1:0] alu_wb_data;
  logic              alu_wb_ready;

  logic              ld_wb_valid;
  logic [ADDR_W-1:0] ld_wb_rd;
  logic [DATA_W-1:0] ld_wb_data;
  logic              ld_wb_ready;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output ld_wb_valid, ld_wb_rd, ld_wb_data,
    input  issue_stall, alu_wb_ready, ld_wb_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  ld_wb_valid, ld_wb_rd, ld_wb_data,
    output issue_stall, alu_wb_ready, ld_wb_ready
  );
endinterface

// File: rtl/regfile_wb_sched_wb_rr_arb.sv
// Two-way round-robin arbiter between ALU and load writeback requesters;
// on a tie the requester not granted last time wins.
module wb_rr_arb
  import regfile_wb_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic ld_valid,
  output logic alu_gnt,
  output logic ld_gnt
);

  req_id_t last_gnt_r;

  // Grant selection from current requests and last winner
  always_comb begin
    alu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    if (alu_valid && ld_valid) begin
      if (last_gnt_r == REQ_LD) begin
        alu_gnt = 1'b1;
      end else begin
        ld_gnt = 1'b1;
      end
    end else begin
      alu_gnt = alu_valid;
      ld_gnt  = ld_valid;
    end
  end

  // Remember the last winner; reset favours the ALU on the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_r <= REQ_LD;
    end else if (alu_gnt) begin
      last_gnt_r <= REQ_ALU;
    end else if (ld_gnt) begin
      last_gnt_r <= REQ_LD;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file writeback scheduler: busy scoreboard with issue stall,
// round-robin writeback arbitration and a registered write port.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_sched_if.slave  wb,
  output logic               reg_wr_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  w_data,
  output logic [NREG-1:0]    busy_vec,
  output logic               wb_err
);

  logic              hazard_s;
  logic              issue_fire_s;
  logic              alu_gnt_s;
  logic              ld_gnt_s;
  logic              gnt_any_s;
  logic [ADDR_W-1:0] gnt_rd_s;
  logic [DATA_W-1:0] gnt_data_s;
  logic [NREG-1:0]   set_mask_s;
  logic [NREG-1:0]   clr_mask_s;
  logic              err_hit_s;

  // Hazard check against the registered scoreboard only
  always_comb begin
    hazard_s = ((wb.issue_rs1 != ADDR_X0) && busy_vec[wb.issue_rs1]) ||
               ((wb.issue_rs2 != ADDR_X0) && busy_vec[wb.issue_rs2]) ||
               ((wb.issue_rd  != ADDR_X0) && busy_vec[wb.issue_rd]);
    wb.issue_stall = wb.issue_valid && hazard_s;
    issue_fire_s   = wb.issue_valid && !hazard_s;
  end

  wb_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (wb.alu_wb_valid),
    .ld_valid  (wb.ld_wb_valid),
    .alu_gnt   (alu_gnt_s),
    .ld_gnt    (ld_gnt_s)
  );

  // Route the winning request and build scoreboard set/clear masks
  always_comb begin
    wb.alu_wb_ready = alu_gnt_s;
    wb.ld_wb_ready  = ld_gnt_s;
    gnt_any_s       = alu_gnt_s || ld_gnt_s;
    if (alu_gnt_s) begin
      gnt_rd_s   = wb.alu_wb_rd;
      gnt_data_s = wb.alu_wb_data;
    end else begin
      gnt_rd_s   = wb.ld_wb_rd;
      gnt_data_s = wb.ld_wb_data;
    end
    set_mask_s = {NREG{1'b0}};
    clr_mask_s = {NREG{1'b0}};
    if (issue_fire_s && (wb.issue_rd != ADDR_X0)) begin
      set_mask_s[wb.issue_rd] = 1'b1;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (gnt_any_s) begin
      clr_mask_s[gnt_rd_s] = 1'b1;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    err_hit_s = gnt_any_s && (gnt_rd_s != ADDR_X0) && !busy_vec[gnt_rd_s];
  end

  // Write port, scoreboard and sticky error; set beats clear, x0 never busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_en <= 1'b0;
      rd_addr   <= ADDR_X0;
      w_data    <= {DATA_W{1'b0}};
      busy_vec  <= {NREG{1'b0}};
      wb_err    <= 1'b0;
    end else begin
      if (gnt_any_s && (gnt_rd_s != ADDR_X0)) begin
        reg_wr_en <= 1'b1;
        rd_addr   <= gnt_rd_s;
        w_data    <= gnt_data_s;
      end else begin
        reg_wr_en <= 1'b0;
      end
      busy_vec <= ((busy_vec & ~clr_mask_s) | set_mask_s) & ~{{(NREG-1){1'b0}}, 1'b1};
      wb_err   <= wb_err || err_hit_s;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized and directed bench for regfile_wb_sched against a
// per-register behavioural model of scoreboard, arbitration and write port.
module tb_regfile_wb_sched;
  import regfile_wb_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] w_data;
  logic [31:0] busy_vec;
  logic        wb_err;

  always #5 clk = ~clk;

  regfile_wb_sched_if #(.DATA_W(32)) bus ();

  regfile_wb_sched #(.DATA_W(32), .NREG(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus),
    .reg_wr_en (reg_wr_en),
    .rd_addr   (rd_addr),
    .w_data    (w_data),
    .busy_vec  (busy_vec),
    .wb_err    (wb_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit        busy_m [32];
  bit        alu_next_m;   // ALU wins the next tie
  bit        wr_en_m;
  bit [4:0]  rd_m;
  bit [31:0] data_m;
  bit        err_m;
  bit        alu_g_m;
  bit        ld_g_m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busy_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = busy_m[i];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    alu_next_m = 1'b1;
    wr_en_m = 1'b0;
    rd_m = 5'd0;
    data_m = 32'd0;
    err_m = 1'b0;
    alu_g_m = 1'b0;
    ld_g_m = 1'b0;
  endtask

  task automatic set_idle();
    bus.issue_valid = 1'b0;
    bus.issue_rs1 = 5'd0;
    bus.issue_rs2 = 5'd0;
    bus.issue_rd = 5'd0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_rd = 5'd0;
    bus.alu_wb_data = 32'd0;
    bus.ld_wb_valid = 1'b0;
    bus.ld_wb_rd = 5'd0;
    bus.ld_wb_data = 32'd0;
  endtask

  function automatic bit reads_busy(input logic [4:0] a);
    return (a != 5'd0) && busy_m[a];
  endfunction

  // One clock: check combinational outputs, advance model, check registered outputs
  task automatic cycle();
    bit        stall_e;
    bit        fire;
    bit [4:0]  ird;
    bit [4:0]  wrd;
    bit [31:0] wdat;
    #1;
    stall_e = bus.issue_valid && (reads_busy(bus.issue_rs1) || reads_busy(bus.issue_rs2) ||
                                  reads_busy(bus.issue_rd));
    alu_g_m = bus.alu_wb_valid && (!bus.ld_wb_valid || alu_next_m);
    ld_g_m  = bus.ld_wb_valid && !alu_g_m;
    check_eq("issue_stall", 64'(bus.issue_stall), 64'(stall_e));
    check_eq("alu_ready", 64'(bus.alu_wb_ready), 64'(alu_g_m));
    check_eq("ld_ready", 64'(bus.ld_wb_ready), 64'(ld_g_m));
    fire = bus.issue_valid && !stall_e;
    ird  = bus.issue_rd;
    wrd  = alu_g_m ? bus.alu_wb_rd : bus.ld_wb_rd;
    wdat = alu_g_m ? bus.alu_wb_data : bus.ld_wb_data;
    @(posedge clk);
    wr_en_m = 1'b0;
    if (alu_g_m || ld_g_m) begin
      alu_next_m = ld_g_m;
      if (wrd != 5'd0) begin
        wr_en_m = 1'b1;
        rd_m = wrd;
        data_m = wdat;
        if (!busy_m[wrd]) err_m = 1'b1;
        busy_m[wrd] = 1'b0;
      end
    end
    if (fire && ird != 5'd0) busy_m[ird] = 1'b1;
    #1;
    check_eq("reg_wr_en", 64'(reg_wr_en), 64'(wr_en_m));
    check_eq("rd_addr", 64'(rd_addr), 64'(rd_m));
    check_eq("w_data", 64'(w_data), 64'(data_m));
    check_eq("busy_vec", 64'(busy_vec), 64'(busy_word()));
    check_eq("wb_err", 64'(wb_err), 64'(err_m));
  endtask

  // Asynchronous reset between clock edges, with whatever requests are pending
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_wr_en", 64'(reg_wr_en), 64'd0);
    check_eq("rst_rd_addr", 64'(rd_addr), 64'd0);
    check_eq("rst_w_data", 64'(w_data), 64'd0);
    check_eq("rst_busy", 64'(busy_vec), 64'd0);
    check_eq("rst_wb_err", 64'(wb_err), 64'd0);
    set_idle();
    @(posedge clk);
    #1;
    check_eq("rst_hold_wr_en", 64'(reg_wr_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1;
    set_idle();
    model_reset();
    do_reset();

    // Tie after reset: ALU first, then load
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd3; bus.alu_wb_data = 32'hAAAA_0001;
    bus.ld_wb_valid  = 1'b1; bus.ld_wb_rd  = 5'd4; bus.ld_wb_data  = 32'h5555_0002;
    cycle();
    check_eq("tie_first_x3", 64'(rd_addr), 64'd3);
    bus.alu_wb_valid = 1'b0;
    cycle();
    check_eq("tie_second_x4", 64'(rd_addr), 64'd4);
    set_idle();
    cycle();
    do_reset();

    // x0 destination never becomes busy and never writes
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    cycle();
    set_idle();
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd0; bus.alu_wb_data = 32'hFFFF_FFFF;
    cycle();
    check_eq("x0_no_write", 64'(reg_wr_en), 64'd0);
    set_idle();
    cycle();

    // RAW stall on x5 until the ALU writeback clears it
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    cycle();
    bus.issue_rs1 = 5'd5; bus.issue_rd = 5'd6;
    cycle();
    cycle();
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd5; bus.alu_wb_data = 32'h1234_5678;
    cycle();
    bus.alu_wb_valid = 1'b0;
    #1;
    check_eq("raw_released", 64'(bus.issue_stall), 64'd0);
    cycle();
    set_idle();
    cycle();

    // Load writeback to a non-busy register: write happens, error sticks
    bus.ld_wb_valid = 1'b1; bus.ld_wb_rd = 5'd7; bus.ld_wb_data = 32'hCAFE_0007;
    cycle();
    set_idle();
    for (int k = 0; k < 3; k++) cycle();
    check_eq("err_sticky", 64'(wb_err), 64'd1);

    // Same-cycle clear and set of x9: set wins
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd9; bus.alu_wb_data = 32'h0000_0009;
    cycle();
    set_idle();
    cycle();
    check_eq("collide_busy9", 64'(busy_vec[9]), 64'd1);
    do_reset();

    // Reset mid-run with x1 and x2 busy
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd1;
    cycle();
    bus.issue_rd = 5'd2;
    cycle();
    set_idle();
    check_eq("pre_rst_busy", 64'(busy_vec), 64'h6);
    do_reset();

    // Random traffic; requesters hold their request until granted
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if (!(bus.alu_wb_valid && !alu_g_m)) begin
        bus.alu_wb_valid = ($urandom_range(0, 2) == 0);
        bus.alu_wb_rd    = 5'($urandom_range(0, 7));
        bus.alu_wb_data  = $urandom;
      end
      if (!(bus.ld_wb_valid && !ld_g_m)) begin
        bus.ld_wb_valid = ($urandom_range(0, 2) == 0);
        bus.ld_wb_rd    = 5'($urandom_range(0, 7));
        bus.ld_wb_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      bus.issue_rs1   = 5'($urandom_range(0, 7));
      bus.issue_rs2   = 5'($urandom_range(0, 7));
      bus.issue_rd    = 5'($urandom_range(0, 7));
      cycle();
    end

    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
